// File: rtl/tc_pkg.sv
// Shared definitions for the tensor-core operand broadcasters and result collector.
// Holds the collector FSM encoding, default array geometry and derived row width.
package tc_pkg;

  // Default array geometry, shared with the A/B broadcasters.
  localparam int TC_DW_DATA  = 16;
  localparam int TC_NUM_TILE = 16;
  localparam int TC_N_PE     = 4;

  // Bits in one PE result row.
  localparam int ROW_W = TC_NUM_TILE * TC_DW_DATA;

  // Collector state: accumulate k-step beats, then drain rows.
  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } tc_state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_sat_add.sv
// One signed element adder for the result accumulator.
// Build switch: TC_C_SAT_EN selects a saturating add; otherwise the add wraps.
module tc_sat_add #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] sum_o
);

`ifdef TC_C_SAT_EN
  logic [DW:0] sum_ext;

  // Add with one guard bit; clamp when the sign bits disagree (overflow).
  always_comb begin
    sum_ext = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
    if (sum_ext[DW] != sum_ext[DW-1]) begin
      sum_o = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sum_o = sum_ext[DW-1:0];
    end
  end
`else
  // Plain two's-complement add, wrapping modulo 2^DW.
  always_comb begin
    sum_o = a_i + b_i;
  end
`endif

endmodule

// File: rtl/tc_c_dn_collect.sv
// Result collector for the dense tensor-core PE array.
// Accumulates STEP full-array partial-sum beats, then drains one PE row per beat.
// Build switch: TC_C_SAT_EN (saturating accumulate, handled in tc_sat_add).
module tc_c_dn_collect
  import tc_pkg::*;
#(
  parameter int NUM_TILE = TC_NUM_TILE,
  parameter int STEP     = 4,
  parameter int DW_DATA  = TC_DW_DATA,
  parameter int N_PE     = TC_N_PE,
  localparam int ROW_BITS = NUM_TILE * DW_DATA,
  localparam int ACC_BITS = N_PE * ROW_BITS,
  localparam int IDX_W    = idx_width(N_PE),
  localparam int CNT_W    = idx_width(STEP)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACC_BITS-1:0] in_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_BITS-1:0] out_c,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last
);

  tc_state_e           state_q, state_d;
  logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_BITS-1:0] sum_w;
  logic [ROW_BITS-1:0] rows_w [0:(1<<IDX_W)-1];

  // Element-wise acc + in_c, one adder per element of the whole array.
  for (genvar gi = 0; gi < N_PE * NUM_TILE; gi++) begin : g_add
    tc_sat_add #(.DW(DW_DATA)) u_add (
      .a_i  (acc_q[gi*DW_DATA +: DW_DATA]),
      .b_i  (in_c[gi*DW_DATA +: DW_DATA]),
      .sum_o(sum_w[gi*DW_DATA +: DW_DATA])
    );
  end

  // Row view of the accumulator; unreachable index slots read as zero.
  for (genvar gi = 0; gi < (1 << IDX_W); gi++) begin : g_row
    if (gi < N_PE) begin : g_live
      assign rows_w[gi] = acc_q[gi*ROW_BITS +: ROW_BITS];
    end else begin : g_pad
      assign rows_w[gi] = '0;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_c     = rows_w[out_idx_q];
  assign out_last  = out_valid_q && (out_idx_q == IDX_W'(N_PE - 1));

  // Next-state: accept/accumulate beats in ACC, advance rows in DRAIN.
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    acc_d       = acc_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          // First beat of a tile overwrites, dropping the previous tile.
          acc_d = (step_cnt_q == '0) ? in_c : sum_w;
          if (step_cnt_q == CNT_W'(STEP - 1)) begin
            step_cnt_d  = '0;
            state_d     = ST_DRAIN;
            out_valid_d = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_idx_q == IDX_W'(N_PE - 1)) begin
            out_idx_d   = '0;
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State registers with asynchronous reset that discards any tile in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACC;
      step_cnt_q  <= '0;
      acc_q       <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      acc_q       <= acc_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
